// File: rtl/dp_pkg.sv
// Shared data-plane types and constants.
// The data-plane receiver uses the same packet type, IDLE_ID and PKT_LEN.
package dp_pkg;

  localparam int          PKT_LEN       = 5;
  localparam logic [15:0] IDLE_ID       = 16'hFFFF;
  localparam int          GRANT_TIMEOUT = 1000;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] data;
  } dp_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GRANT,
    ST_SEND,
    ST_DONE
  } tx_state_e;

  function automatic dp_packet_t idle_packet();
    dp_packet_t p;
    p.dest = IDLE_ID;
    p.data = 16'h0000;
    return p;
  endfunction

endpackage

// File: rtl/dp_tx_stack.sv
// LIFO word stack for the data-plane transmitter.
// top_data always shows mem[sp-1], which is the next word to pop.
module dp_tx_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  top_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] sp;
  logic [LW-1:0] sp_m1;

  assign sp_m1    = sp - LW'(1);
  assign full     = (sp == LW'(DEPTH));
  assign empty    = (sp == '0);
  assign level    = sp;
  assign top_data = mem[sp_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= wdata;
    end
  end

  // A push beats a pop if both ever arrive together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + LW'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/data_plane_tx.sv
// Data-plane transmitter: stacks GPP words and sends PKT_LEN-word packets once granted.
// Optional macro DP_TX_GRANT_TIMEOUT_EN makes WAIT_GRANT give up after GRANT_TIMEOUT cycles.
//
// state       | meaning
// ST_IDLE     | stack open for pushes, bus idle, waiting for tx_start
// ST_WAIT_GRANT | destination latched, bus idle, waiting for tx_grant
// ST_SEND     | one packet per cycle, PKT_LEN beats, stack locked
// ST_DONE     | bus idle, completion flag high for this cycle
module data_plane_tx
  import dp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              node_id,
  input  logic                     gpp_wr_dp,
  input  logic [15:0]              gpp_data_in,
  input  logic                     tx_start,
  input  logic [15:0]              tx_dest_id,
  input  logic                     tx_grant,
  output logic [31:0]              data_tx_packet,
  output logic                     tx_busy,
  output logic                     data_tx_complete_flag,
  output logic                     tx_reject,
  output logic [$clog2(DEPTH):0]   tx_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(PKT_LEN);

  tx_state_e     state_q, state_d;
  dp_packet_t    pkt_q, pkt_d;
  logic [15:0]   dest_q, dest_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          reject_q, reject_d;
  logic          push, pop;
  logic          start_ok;
  logic [15:0]   top_data;
  logic          full, empty;
  logic [LW-1:0] level;

`ifdef DP_TX_GRANT_TIMEOUT_EN
  logic [15:0]   tmr_q, tmr_d;
`endif

  dp_tx_stack #(.DEPTH(DEPTH), .W(16), .LW(LW)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    (gpp_data_in),
    .top_data (top_data),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Start is judged on the pre-push level, so a same-cycle push never counts.
  assign start_ok = (level >= LW'(PKT_LEN)) && (tx_dest_id != node_id) &&
                    (tx_dest_id != IDLE_ID);
  assign push     = gpp_wr_dp && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    dest_d   = dest_q;
    beat_d   = beat_q;
    reject_d = 1'b0;
    pop      = 1'b0;
`ifdef DP_TX_GRANT_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          if (start_ok) begin
            dest_d  = tx_dest_id;
            state_d = ST_WAIT_GRANT;
`ifdef DP_TX_GRANT_TIMEOUT_EN
            tmr_d   = 16'(GRANT_TIMEOUT - 1);
`endif
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_WAIT_GRANT: begin
        if (tx_grant) begin
          state_d    = ST_SEND;
          pkt_d.dest = dest_q;
          pkt_d.data = top_data;
          pop        = 1'b1;
          beat_d     = '0;
        end
`ifdef DP_TX_GRANT_TIMEOUT_EN
        else if (tmr_q == '0) begin
          state_d  = ST_IDLE;
          reject_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
`endif
      end
      ST_SEND: begin
        // The packet for each beat is loaded on the edge that enters it.
        if (beat_q == BW'(PKT_LEN - 1)) begin
          state_d = ST_DONE;
          pkt_d   = idle_packet();
        end else begin
          pkt_d.dest = dest_q;
          pkt_d.data = top_data;
          pop        = 1'b1;
          beat_d     = beat_q + BW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pkt_d   = idle_packet();
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pkt_q    <= idle_packet();
      dest_q   <= IDLE_ID;
      beat_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      dest_q   <= dest_d;
      beat_q   <= beat_d;
      reject_q <= reject_d;
    end
  end

`ifdef DP_TX_GRANT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`endif

  assign data_tx_packet        = pkt_q;
  assign tx_busy               = (state_q != ST_IDLE);
  assign data_tx_complete_flag = (state_q == ST_DONE);
  assign tx_reject             = reject_q;
  assign tx_level              = level;

endmodule

// File: tb/tb_data_plane_tx.sv
// Directed bench for data_plane_tx: start-acceptance table plus hand-written transfer sequences.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_data_plane_tx;

  logic        clk;
  logic        rst;
  logic [15:0] node_id;
  logic        gpp_wr_dp;
  logic [15:0] gpp_data_in;
  logic        tx_start;
  logic [15:0] tx_dest_id;
  logic        tx_grant;
  logic [31:0] data_tx_packet;
  logic        tx_busy;
  logic        data_tx_complete_flag;
  logic        tx_reject;
  logic [4:0]  tx_level;

  int checks   = 0;
  int failures = 0;

  data_plane_tx #(.DEPTH(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .gpp_wr_dp             (gpp_wr_dp),
    .gpp_data_in           (gpp_data_in),
    .tx_start              (tx_start),
    .tx_dest_id            (tx_dest_id),
    .tx_grant              (tx_grant),
    .data_tx_packet        (data_tx_packet),
    .tx_busy               (tx_busy),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_reject             (tx_reject),
    .tx_level              (tx_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gpp_wr_dp = 1'b0;
    tx_start = 1'b0;
    tx_grant = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      gpp_wr_dp   = 1'b1;
      gpp_data_in = base + 16'(i);
      @(negedge clk);
    end
    gpp_wr_dp = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] dest);
    tx_start   = 1'b1;
    tx_dest_id = dest;
    @(negedge clk);
    tx_start   = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          n_push;
    logic [15:0] dest;
    logic        exp_reject;
    logic        exp_busy;
    logic [4:0]  exp_level;
  } start_vec_t;

  start_vec_t vecs [5];

  initial begin
    node_id     = 16'h0002;
    gpp_data_in = '0;
    tx_dest_id  = '0;
    rst         = 1'b1;
    gpp_wr_dp   = 1'b0;
    tx_start    = 1'b0;
    tx_grant    = 1'b0;

    vecs[0] = '{"short_stack", 3, 16'h0003, 1'b1, 1'b0, 5'd3};
    vecs[1] = '{"self_dest",   6, 16'h0002, 1'b1, 1'b0, 5'd6};
    vecs[2] = '{"idle_dest",   5, 16'hFFFF, 1'b1, 1'b0, 5'd5};
    vecs[3] = '{"four_words",  4, 16'h0007, 1'b1, 1'b0, 5'd4};
    vecs[4] = '{"accept_min",  5, 16'h0007, 1'b0, 1'b1, 5'd5};

    // Reset state
    do_reset();
    check("rst_packet",   data_tx_packet, 32'hFFFF0000);
    check("rst_busy",     {31'd0, tx_busy}, 32'd0);
    check("rst_complete", {31'd0, data_tx_complete_flag}, 32'd0);
    check("rst_reject",   {31'd0, tx_reject}, 32'd0);
    check("rst_level",    {27'd0, tx_level}, 32'd0);

    // Start-acceptance table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_words(vecs[v].n_push, 16'h0040);
      pulse_start(vecs[v].dest);
      check({vecs[v].name, "_reject"}, {31'd0, tx_reject}, {31'd0, vecs[v].exp_reject});
      check({vecs[v].name, "_busy"},   {31'd0, tx_busy},   {31'd0, vecs[v].exp_busy});
      check({vecs[v].name, "_bus"},    data_tx_packet,     32'hFFFF0000);
      check({vecs[v].name, "_level"},  {27'd0, tx_level},  {27'd0, vecs[v].exp_level});
      @(negedge clk);
      check({vecs[v].name, "_reject_once"}, {31'd0, tx_reject}, 32'd0);
    end

    // Basic transfer, grant after 3 cycles, grant dropped mid-send
    do_reset();
    push_words(5, 16'h0011);
    pulse_start(16'h0003);
    for (int i = 0; i < 3; i++) begin
      check("wait_bus_idle", data_tx_packet, 32'hFFFF0000);
      check("wait_busy", {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
    end
    tx_grant = 1'b1;
    @(negedge clk);
    tx_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("send_packet", data_tx_packet, {16'h0003, 16'h0015 - 16'(i)});
      check("send_no_complete", {31'd0, data_tx_complete_flag}, 32'd0);
      @(negedge clk);
    end
    check("done_bus_idle", data_tx_packet, 32'hFFFF0000);
    check("done_complete", {31'd0, data_tx_complete_flag}, 32'd1);
    @(negedge clk);
    check("after_complete", {31'd0, data_tx_complete_flag}, 32'd0);
    check("after_busy", {31'd0, tx_busy}, 32'd0);
    check("after_level", {27'd0, tx_level}, 32'd0);

    // Full stack drops the 17th push; push during SEND ignored
    do_reset();
    push_words(17, 16'h0100);
    check("full_level", {27'd0, tx_level}, 32'd16);
    pulse_start(16'h0003);
    tx_grant = 1'b1;
    @(negedge clk);
    tx_grant = 1'b0;
    check("full_first_pkt", data_tx_packet, 32'h0003010F);
    gpp_wr_dp   = 1'b1;
    gpp_data_in = 16'hBEEF;
    @(negedge clk);
    gpp_wr_dp = 1'b0;
    check("full_second_pkt", data_tx_packet, 32'h0003010E);
    repeat (4) @(negedge clk);
    check("full_done", {31'd0, data_tx_complete_flag}, 32'd1);
    @(negedge clk);
    check("full_level_after", {27'd0, tx_level}, 32'd11);

    // Reset on the third SEND beat
    do_reset();
    push_words(6, 16'h0200);
    pulse_start(16'h0009);
    tx_grant = 1'b1;
    @(negedge clk);
    tx_grant = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_beat3", data_tx_packet, 32'h00090203);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_bus", data_tx_packet, 32'hFFFF0000);
    check("mid_rst_level", {27'd0, tx_level}, 32'd0);
    check("mid_rst_complete", {31'd0, data_tx_complete_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_complete2", {31'd0, data_tx_complete_flag}, 32'd0);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);

    // Grant never arrives
    do_reset();
    push_words(5, 16'h0300);
    pulse_start(16'h0004);
`ifdef DP_TX_GRANT_TIMEOUT_EN
    begin
      int waited = 0;
      while (!tx_reject && waited < 1200) begin
        @(negedge clk);
        waited++;
      end
      check("timeout_seen", {31'd0, tx_reject}, 32'd1);
      check("timeout_window", {31'd0, (waited >= 995 && waited <= 1005)}, 32'd1);
      check("timeout_busy", {31'd0, tx_busy}, 32'd0);
      check("timeout_level", {27'd0, tx_level}, 32'd5);
    end
`else
    repeat (2000) @(negedge clk);
    check("nogrant_busy", {31'd0, tx_busy}, 32'd1);
    check("nogrant_bus", data_tx_packet, 32'hFFFF0000);
    check("nogrant_reject", {31'd0, tx_reject}, 32'd0);
    check("nogrant_level", {27'd0, tx_level}, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_plane_tx.md
Name: data_plane_tx

Overview:
Data-plane transmitter for one node; it is the source-side counterpart of the data-plane receiver. The GPP pushes 16-bit words into a local LIFO stack. On a start request the block waits for the control-plane path grant. It then drives one 32-bit packet per cycle, {dest_id[15:0], data[15:0]}, for exactly PKT_LEN cycles. After the last word it pulses a completion flag for one cycle. When not sending, the bus carries IDLE_ID in the destination field, so no receiver matches.

Parameters:
PKT_LEN, 5, words per transfer; the receiver counts 0..4, so 5 words.
DEPTH, 16, LIFO stack entries (power of 2).
IDLE_ID, 16'hFFFF, destination field driven when idle; never assigned as a node_id.

Ports:
clk  in  1  system clock
rst  in  1  reset
node_id  in  16  this node's id
gpp_wr_dp  in  1  push gpp_data_in onto the TX stack
gpp_data_in  in  16  word to push
tx_start  in  1  request transfer (single-cycle pulse)
tx_dest_id  in  16  destination, sampled with tx_start
tx_grant  in  1  control plane has reserved the path
data_tx_packet  out  32  packet onto the data plane, registered
tx_busy  out  1  high in every state except IDLE
data_tx_complete_flag  out  1  one-cycle pulse after the last word
tx_reject  out  1  one-cycle pulse when tx_start is refused
tx_level  out  $clog2(DEPTH)+1  words currently stacked

Behaviour:
- Reset rst is synchronous and active-high; clock is clk. On reset:
  - state=IDLE, sp=0.
  - data_tx_packet={IDLE_ID,16'h0000}.
  - tx_busy, data_tx_complete_flag, tx_reject and tx_level are all 0.
- Stack:
  - A push in IDLE when sp<DEPTH writes mem[sp] and increments sp.
  - A push when full is dropped; sp is unchanged.
  - Pushes outside IDLE are ignored, so the stack is locked during a transfer.
  - Pop order is LIFO; the first word sent is mem[sp-1].
- FSM IDLE -> WAIT_GRANT -> SEND -> DONE -> IDLE.
- IDLE:
  - tx_start is accepted when sp>=PKT_LEN and tx_dest_id!=node_id and tx_dest_id!=IDLE_ID. It latches dest and moves to WAIT_GRANT.
  - Otherwise tx_reject pulses on the next cycle and the state stays IDLE.
  - Push and start in the same cycle: the push is applied, and start is evaluated against the pre-push sp.
- WAIT_GRANT: the bus stays idle. When tx_grant=1 (sampled), move to SEND.
- SEND:
  - Each cycle the registered output is {dest, mem[sp-1]} and sp decrements.
  - A beat counter counts 0..PKT_LEN-1. After beat PKT_LEN-1, move to DONE.
  - Exactly PKT_LEN consecutive packets go out, with no gaps.
  - tx_grant dropping mid-SEND is ignored; the transfer is never split.
- DONE:
  - The output returns to {IDLE_ID,0}.
  - data_tx_complete_flag=1 for this cycle only.
  - Next state is IDLE.
- Latency: first packet appears 1 cycle after the tx_grant sample. Total occupancy from start is at least PKT_LEN+2 cycles.
- The stack pointer never underflows, because start requires sp>=PKT_LEN.
- Reset mid-SEND: the bus shows IDLE_ID on the next edge, the stack is emptied and no completion flag is raised.
- tx_level=sp, updated registered.

Optional Feature:
Macro DP_TX_GRANT_TIMEOUT_EN.
- Defined: WAIT_GRANT runs a 16-bit counter. If tx_grant has not arrived after GRANT_TIMEOUT cycles (localparam 1000), the state returns to IDLE, tx_reject pulses once and the stack contents are kept.
- Undefined: WAIT_GRANT waits indefinitely; no counter is synthesised.

Decomposition:
- Package dp_pkg holds:
  - typedef dp_packet_t: packed struct {logic[15:0] dest; logic[15:0] data}.
  - IDLE_ID, PKT_LEN and GRANT_TIMEOUT.
  - The FSM state enum tx_state_e.
- The receiver also adopts dp_packet_t, IDLE_ID and PKT_LEN.
- One sub-module, dp_tx_stack: LIFO with push, pop, full/empty and level. The FSM stays in data_plane_tx.

Test Plan:
1. Push 5 words 0x0011..0x0015, start dest=0x0003, grant after 3 cycles -> packets 0x00030015, 0x00030014, 0x00030013, 0x00030012, 0x00030011 on consecutive cycles; complete pulse of 1 cycle; tx_level returns to 0.
2. Push 3 words, start -> tx_reject pulses, state IDLE, bus 0xFFFF0000, tx_level=3.
3. node_id=0x0002, start dest=0x0002 with 6 words stacked -> tx_reject; nothing sent.
4. Push 17 words with DEPTH=16 -> tx_level=16; a push during SEND is ignored, so tx_level=11 after the transfer.
5. Assert rst on the 3rd SEND beat -> next cycle bus=0xFFFF0000, tx_level=0, no complete pulse.
6. With DP_TX_GRANT_TIMEOUT_EN, grant held at 0 -> tx_reject after 1000 cycles and tx_level preserved. Without the macro, the block is still in WAIT_GRANT at cycle 2000.
